// File: rtl/mt_fetch_sched.sv
// Round-robin multithreaded fetch scheduler with a per-thread PC file.
// Define FETCH_STRICT_SLOT_EN for strict barrel slotting; otherwise inactive threads are skipped.
module mt_fetch_sched #(
    parameter int                     NUM_THREADS = 4,
    parameter int                     TID_W       = $clog2(NUM_THREADS),
    parameter int                     PC_W        = 9,
    parameter int                     PC_STEP     = 4,
    parameter logic [PC_W-1:0]        RESET_PC    = '0,
    parameter logic [NUM_THREADS-1:0] RESET_MASK  = '1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   stall,
    input  logic                   redir_valid,
    input  logic [TID_W-1:0]       redir_tid,
    input  logic [PC_W-1:0]        redir_pc,
    input  logic                   start_valid,
    input  logic [TID_W-1:0]       start_tid,
    input  logic [PC_W-1:0]        start_pc,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_tid,
    output logic                   fetch_valid,
    output logic [TID_W-1:0]       fetch_tid,
    output logic [PC_W-1:0]        fetch_pc,
    output logic [PC_W-1:0]        fetch_pc_next,
    output logic [NUM_THREADS-1:0] active_mask
);

    logic [PC_W-1:0]        pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] active;
    logic [TID_W-1:0]       last_tid;

    logic [NUM_THREADS-1:0] eligible;
    logic                   issue;
    logic [TID_W-1:0]       sel;

    // A thread being redirected this cycle must not fetch down its stale path.
    always_comb begin
        eligible = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = active[t] && !(redir_valid && (redir_tid == TID_W'(t)));
        end
    end

`ifdef FETCH_STRICT_SLOT_EN
    always_comb begin
        sel   = (32'(last_tid) == NUM_THREADS - 1) ? '0 : last_tid + 1'b1;
        issue = eligible[sel];
    end
`else
    // Scan farthest offset first so the nearest eligible thread wins.
    always_comb begin
        int unsigned idx;
        issue = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = NUM_THREADS; k > 0; k--) begin
            idx = (32'(last_tid) + k) % NUM_THREADS;
            if (eligible[idx]) begin
                issue = 1'b1;
                sel   = TID_W'(idx);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                pc[t] <= RESET_PC;
            end
            active      <= RESET_MASK;
            last_tid    <= TID_W'(NUM_THREADS - 1);
            fetch_valid <= 1'b0;
            fetch_tid   <= '0;
            fetch_pc    <= RESET_PC;
        end else begin
            // PC priority: start, then redirect, then sequential increment.
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                if (start_valid && (start_tid == TID_W'(t))) begin
                    pc[t] <= start_pc;
                end else if (redir_valid && (redir_tid == TID_W'(t))) begin
                    pc[t] <= redir_pc;
                end else if (issue && !stall && (sel == TID_W'(t))) begin
                    pc[t] <= pc[t] + PC_W'(PC_STEP);
                end

                if (halt_valid && (halt_tid == TID_W'(t))) begin
                    active[t] <= 1'b0;
                end else if (start_valid && (start_tid == TID_W'(t))) begin
                    active[t] <= 1'b1;
                end
            end

            if (!stall) begin
                fetch_valid <= issue;
                if (issue) begin
                    fetch_tid <= sel;
                    fetch_pc  <= pc[sel];
                end
`ifdef FETCH_STRICT_SLOT_EN
                last_tid <= sel;
`else
                if (issue) begin
                    last_tid <= sel;
                end
`endif
            end
        end
    end

    assign fetch_pc_next = fetch_pc + PC_W'(PC_STEP);
    assign active_mask   = active;

endmodule

// File: tb/tb_mt_fetch_sched.sv
// Scoreboard bench for mt_fetch_sched (4 threads, PC_W=9): stimulus queues expected fetch outputs, a monitor checks them.
module tb_mt_fetch_sched;

    logic       clk = 1'b0;
    logic       rstb;
    logic       stall;
    logic       redir_valid;
    logic [1:0] redir_tid;
    logic [8:0] redir_pc;
    logic       start_valid;
    logic [1:0] start_tid;
    logic [8:0] start_pc;
    logic       halt_valid;
    logic [1:0] halt_tid;
    logic       fetch_valid;
    logic [1:0] fetch_tid;
    logic [8:0] fetch_pc;
    logic [8:0] fetch_pc_next;
    logic [3:0] active_mask;

    always #5 clk = ~clk;

    mt_fetch_sched #(
        .NUM_THREADS(4),
        .PC_W(9),
        .PC_STEP(4),
        .RESET_PC(9'h000),
        .RESET_MASK(4'b1111)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .stall(stall),
        .redir_valid(redir_valid),
        .redir_tid(redir_tid),
        .redir_pc(redir_pc),
        .start_valid(start_valid),
        .start_tid(start_tid),
        .start_pc(start_pc),
        .halt_valid(halt_valid),
        .halt_tid(halt_tid),
        .fetch_valid(fetch_valid),
        .fetch_tid(fetch_tid),
        .fetch_pc(fetch_pc),
        .fetch_pc_next(fetch_pc_next),
        .active_mask(active_mask)
    );

    typedef struct {
        logic       v;
        logic [1:0] tid;
        logic [8:0] pc;
        logic [8:0] pc_next;
        logic [3:0] mask;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   sn     = 0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (fetch_valid === e.v && fetch_tid === e.tid && fetch_pc === e.pc &&
                fetch_pc_next === e.pc_next && active_mask === e.mask) begin
                passed++;
            end else begin
                $display("FAIL fetch step %0d: got v=%0b tid=%0d pc=%h next=%h mask=%b, expected v=%0b tid=%0d pc=%h next=%h mask=%b",
                         e.step, fetch_valid, fetch_tid, fetch_pc, fetch_pc_next, active_mask,
                         e.v, e.tid, e.pc, e.pc_next, e.mask);
            end
        end
    end

    // One clock edge with the currently driven inputs; queue the outputs expected after it.
    task automatic step(input logic v, input int t, input int p, input int pn, input int m);
        exp_t e;
        @(posedge clk);
        e.v       = v;
        e.tid     = 2'(t);
        e.pc      = 9'(p);
        e.pc_next = 9'(pn);
        e.mask    = 4'(m);
        e.step    = sn;
        exp_q.push_back(e);
        sn++;
        @(negedge clk);
        redir_valid = 1'b0;
        start_valid = 1'b0;
        halt_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rstb  = 1'b0;
        stall = 1'b0;
        step(0, 0, 'h000, 'h004, 'hF);
        rstb = 1'b1;
    endtask

    task automatic redir(input int t, input int p);
        redir_valid = 1'b1;
        redir_tid   = 2'(t);
        redir_pc    = 9'(p);
    endtask

    task automatic halt(input int t);
        halt_valid = 1'b1;
        halt_tid   = 2'(t);
    endtask

    task automatic start(input int t, input int p);
        start_valid = 1'b1;
        start_tid   = 2'(t);
        start_pc    = 9'(p);
    endtask

    initial begin
        rstb        = 1'b0;
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_tid   = '0;
        redir_pc    = '0;
        start_valid = 1'b0;
        start_tid   = '0;
        start_pc    = '0;
        halt_valid  = 1'b0;
        halt_tid    = '0;

        // Round robin from reset
        do_reset();
        step(1, 0, 'h000, 'h004, 'hF);
        step(1, 1, 'h000, 'h004, 'hF);
        step(1, 2, 'h000, 'h004, 'hF);
        step(1, 3, 'h000, 'h004, 'hF);
        step(1, 0, 'h004, 'h008, 'hF);
        step(1, 1, 'h004, 'h008, 'hF);
        step(1, 2, 'h004, 'h008, 'hF);
        step(1, 3, 'h004, 'h008, 'hF);

        // Halt tid 2 (mid-operation reset first)
        do_reset();
        halt(2);
        step(1, 0, 'h000, 'h004, 'hB);
        step(1, 1, 'h000, 'h004, 'hB);
`ifdef FETCH_STRICT_SLOT_EN
        step(0, 1, 'h000, 'h004, 'hB);
        step(1, 3, 'h000, 'h004, 'hB);
        step(1, 0, 'h004, 'h008, 'hB);
        step(1, 1, 'h004, 'h008, 'hB);
`else
        step(1, 3, 'h000, 'h004, 'hB);
        step(1, 0, 'h004, 'h008, 'hB);
        step(1, 1, 'h004, 'h008, 'hB);
        step(1, 3, 'h004, 'h008, 'hB);
`endif

        // Redirect tid 1 in the cycle it would issue
        do_reset();
        step(1, 0, 'h000, 'h004, 'hF);
        redir(1, 'h040);
`ifdef FETCH_STRICT_SLOT_EN
        step(0, 0, 'h000, 'h004, 'hF);
        step(1, 2, 'h000, 'h004, 'hF);
        step(1, 3, 'h000, 'h004, 'hF);
        step(1, 0, 'h004, 'h008, 'hF);
        step(1, 1, 'h040, 'h044, 'hF);
        step(1, 2, 'h004, 'h008, 'hF);
        step(1, 3, 'h004, 'h008, 'hF);
        step(1, 0, 'h008, 'h00C, 'hF);
        step(1, 1, 'h044, 'h048, 'hF);
`else
        step(1, 2, 'h000, 'h004, 'hF);
        step(1, 3, 'h000, 'h004, 'hF);
        step(1, 0, 'h004, 'h008, 'hF);
        step(1, 1, 'h040, 'h044, 'hF);
        step(1, 2, 'h004, 'h008, 'hF);
        step(1, 3, 'h004, 'h008, 'hF);
        step(1, 0, 'h008, 'h00C, 'hF);
        step(1, 1, 'h044, 'h048, 'hF);
`endif

        // Stall three cycles with a redirect of tid 0
        do_reset();
        step(1, 0, 'h000, 'h004, 'hF);
        step(1, 1, 'h000, 'h004, 'hF);
        stall = 1'b1;
        redir(0, 'h080);
        step(1, 1, 'h000, 'h004, 'hF);
        step(1, 1, 'h000, 'h004, 'hF);
        step(1, 1, 'h000, 'h004, 'hF);
        stall = 1'b0;
        step(1, 2, 'h000, 'h004, 'hF);
        step(1, 3, 'h000, 'h004, 'hF);
        step(1, 0, 'h080, 'h084, 'hF);
        step(1, 1, 'h004, 'h008, 'hF);

        // Single active thread; start+halt same tid, then start alone
        do_reset();
`ifdef FETCH_STRICT_SLOT_EN
        halt(1);
        step(1, 0, 'h000, 'h004, 'hD);
        halt(2);
        step(0, 0, 'h000, 'h004, 'h9);
        halt(3);
        step(0, 0, 'h000, 'h004, 'h1);
        step(0, 0, 'h000, 'h004, 'h1);
        step(1, 0, 'h004, 'h008, 'h1);
        start(3, 'h100);
        halt(3);
        step(0, 0, 'h004, 'h008, 'h1);
        step(0, 0, 'h004, 'h008, 'h1);
        start(3, 'h100);
        step(0, 0, 'h004, 'h008, 'h9);
        step(1, 0, 'h008, 'h00C, 'h9);
        step(0, 0, 'h008, 'h00C, 'h9);
        step(0, 0, 'h008, 'h00C, 'h9);
        step(1, 3, 'h100, 'h104, 'h9);
`else
        halt(1);
        step(1, 0, 'h000, 'h004, 'hD);
        halt(2);
        step(1, 2, 'h000, 'h004, 'h9);
        halt(3);
        step(1, 3, 'h000, 'h004, 'h1);
        step(1, 0, 'h004, 'h008, 'h1);
        step(1, 0, 'h008, 'h00C, 'h1);
        start(3, 'h100);
        halt(3);
        step(1, 0, 'h00C, 'h010, 'h1);
        step(1, 0, 'h010, 'h014, 'h1);
        start(3, 'h100);
        step(1, 0, 'h014, 'h018, 'h9);
        step(1, 3, 'h100, 'h104, 'h9);
        step(1, 0, 'h018, 'h01C, 'h9);
        step(1, 3, 'h104, 'h108, 'h9);
`endif

        // PC wrap at 9 bits
        do_reset();
        redir(0, 'h1FC);
`ifdef FETCH_STRICT_SLOT_EN
        step(0, 0, 'h000, 'h004, 'hF);
`endif
        step(1, 1, 'h000, 'h004, 'hF);
        step(1, 2, 'h000, 'h004, 'hF);
        step(1, 3, 'h000, 'h004, 'hF);
        step(1, 0, 'h1FC, 'h000, 'hF);
        step(1, 1, 'h004, 'h008, 'hF);
        step(1, 2, 'h004, 'h008, 'hF);
        step(1, 3, 'h004, 'h008, 'hF);
        step(1, 0, 'h000, 'h004, 'hF);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mt_fetch_sched.md
# mt_fetch_sched

Parametrised multithreaded fetch scheduler and per-thread PC file for the barrel-pipelined ARM core. Each cycle it selects one hardware thread round-robin and presents that thread's PC to instruction memory, tagged with the thread id. It absorbs EX-stage branch redirects, starts and halts individual threads, and honours a pipeline stall. It replaces the fixed 4-thread counter-plus-PC arrangement in the fetch stage.

## Interface
Parameters:
- NUM_THREADS, 4, number of hardware threads (2..16)
- TID_W, $clog2(NUM_THREADS), thread-id width
- PC_W, 9, PC width in bits
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, PC loaded into every thread at reset
- RESET_MASK, all ones, per-thread active bits after reset

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rstb  in  1  synchronous, active-low reset
- stall  in  1  hold fetch outputs; no issue this cycle
- redir_valid  in  1  EX branch taken
- redir_tid  in  TID_W  thread being redirected
- redir_pc  in  PC_W  branch target
- start_valid  in  1  activate a thread
- start_tid  in  TID_W  thread to start
- start_pc  in  PC_W  start address
- halt_valid  in  1  deactivate a thread
- halt_tid  in  TID_W  thread to halt
- fetch_valid  out  1  fetch_pc/fetch_tid are a real fetch
- fetch_tid  out  TID_W  thread of current fetch
- fetch_pc  out  PC_W  imem address
- fetch_pc_next  out  PC_W  fetch_pc + PC_STEP (combinational from fetch_pc)
- active_mask  out  NUM_THREADS  current per-thread active bits

## Operation
- State: pc[NUM_THREADS], active[NUM_THREADS], last_tid.
- Eligible thread: active[t]=1 and not (redir_valid and redir_tid==t).
- Issue (rising edge, stall=0): pick first eligible t scanning last_tid+1, +2, … mod NUM_THREADS. fetch_pc<=pc[t], fetch_tid<=t, fetch_valid<=1, pc[t]<=pc[t]+PC_STEP, last_tid<=t.
- No eligible thread: fetch_valid<=0, fetch_pc/fetch_tid hold, last_tid unchanged.
- Redirect: pc[redir_tid]<=redir_pc; overrides the increment; applied even when the thread is inactive (thread stays inactive).
- Start: active[start_tid]<=1, pc[start_tid]<=start_pc. Redirect to the same tid in the same cycle: start_pc wins.
- Halt: active[halt_tid]<=0; pc kept. Halt and start on the same tid in the same cycle: halt wins, pc still loads start_pc.
- Halting the thread whose fetch is currently presented does not retract fetch_valid; downstream squash is outside this block.
- PC arithmetic wraps modulo 2^PC_W; redir_pc/start_pc used unmodified.
- stall=1: fetch outputs and last_tid hold; redirect/start/halt still update pc/active.

## Timing
- Reset (rstb=0 at edge): pc[*]=RESET_PC, active=RESET_MASK, last_tid=NUM_THREADS-1, fetch_valid=0, fetch_tid=0, fetch_pc=RESET_PC, active_mask=RESET_MASK. Reset mid-operation discards all pending state within that edge.
- First issue on the first edge with rstb=1, stall=0; thread 0 is first if active.
- Latency: redirect at edge N is visible in fetch_pc on that thread's next issue, earliest edge N+1.
- active_mask reflects the register, so start/halt become visible one cycle after the edge.
- Throughput: one fetch per non-stalled cycle while any thread is eligible.

## Configuration
- FETCH_STRICT_SLOT_EN defined: strict barrel slotting. last_tid advances by exactly 1 every non-stalled cycle. If the slot thread is not eligible, fetch_valid<=0, which produces a bubble. Guaranteed spacing of NUM_THREADS cycles between same-thread fetches; the no-forwarding pipeline requires this.
- Undefined: skip-ahead selection as in Operation; inactive threads consume no slots.

## Test plan
- Reset, all 4 active, RESET_PC=0, 8 cycles -> fetch_tid 0,1,2,3,0,1,2,3; fetch_pc 0,0,0,0,4,4,4,4.
- Halt tid 2 after reset, default build -> tid sequence 0,1,3,0,1,3; with FETCH_STRICT_SLOT_EN -> 0,1,bubble,3 with fetch_valid=0 in tid-2 slot.
- Redirect tid 1 to 0x40 in the cycle tid 1 would issue -> tid 1 skipped that cycle; next tid-1 fetch_pc=0x40, following one 0x44.
- stall=1 for 3 cycles with a redirect of tid 0 to 0x80 -> outputs frozen; after release, tid 0 fetches 0x80.
- RESET_MASK=4'b0001, start tid 3 at 0x100 with simultaneous halt tid 3 -> active_mask stays 0001, pc[3]=0x100; later start alone -> tid 3 fetches 0x100.
- pc[0]=0x1FC, issue -> next tid-0 fetch_pc=0x000 (PC_W=9 wrap); fetch_pc_next=0x000 while fetch_pc=0x1FC.
